// File: rtl/spi_main_if.sv
// Bundles the command-side handshake and the SPI pin signals of spi_main.
// The master modport is the controller's view; slave is the command logic / pins view.
interface spi_main_if #(
  parameter int WORD_BITS = 8
);
  logic                 start;
  logic [WORD_BITS-1:0] word_to_send;
  logic                 busy;
  logic                 done;
  logic [WORD_BITS-1:0] word_received;
  logic                 neg_enable;
  logic                 sck;
  logic                 out_bit;
  logic                 in_bit;

  modport master (
    input  start, word_to_send, in_bit,
    output busy, done, word_received, neg_enable, sck, out_bit
  );

  modport slave (
    output start, word_to_send, in_bit,
    input  busy, done, word_received, neg_enable, sck, out_bit
  );
endinterface

// File: rtl/spi_main.sv
// SPI mode-0 MSB-first controller exchanging one WORD_BITS word per start request.
// Define SPI_MAIN_BURST_EN to chain back-to-back words without releasing chip select.
//
// state      | meaning
// S_IDLE     | chip select high, waiting for start
// S_SETUP    | chip select low, MSB on out_bit, sck low
// S_SHIFT_HI | sck high; last cycle samples in_bit and shifts TX
// S_SHIFT_LO | sck low, out_bit stable
// S_HOLD     | chip select still low after the last falling sck edge
module spi_main #(
  parameter int WORD_BITS = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic        clk,
  input  logic        rst,
  spi_main_if.master  bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(WORD_BITS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_HI,
    S_SHIFT_LO,
    S_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [WORD_BITS-1:0] tx_q, tx_d;
  logic [WORD_BITS-1:0] rx_q, rx_d;
  logic [WORD_BITS-1:0] word_received_q, word_received_d;
  logic                 sck_q, sck_d;
  logic                 neg_enable_q, neg_enable_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 out_bit_q, out_bit_d;

  logic div_last;
  logic last_bit;
  logic burst_go;
  logic accept;

`ifdef SPI_MAIN_BURST_EN
  assign burst_go = bus.start;
`else
  assign burst_go = 1'b0;
`endif

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_q == BIT_W'(WORD_BITS - 1));
  assign accept   = ((state_q == S_IDLE) && bus.start) ||
                    ((state_q == S_HOLD) && div_last && burst_go);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      div_q           <= '0;
      bit_q           <= '0;
      tx_q            <= '0;
      rx_q            <= '0;
      word_received_q <= '0;
      sck_q           <= 1'b0;
      neg_enable_q    <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      out_bit_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      div_q           <= div_d;
      bit_q           <= bit_d;
      tx_q            <= tx_d;
      rx_q            <= rx_d;
      word_received_q <= word_received_d;
      sck_q           <= sck_d;
      neg_enable_q    <= neg_enable_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      out_bit_q       <= out_bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = (state_q == S_IDLE || div_last) ? '0 : div_q + DIV_W'(1);
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    case (state_q)
      S_IDLE:     if (bus.start) state_d = S_SETUP;
      S_SETUP:    if (div_last) state_d = S_SHIFT_HI;
      S_SHIFT_HI: if (div_last) state_d = last_bit ? S_HOLD : S_SHIFT_LO;
      S_SHIFT_LO: if (div_last) state_d = S_SHIFT_HI;
      S_HOLD:     if (div_last) state_d = burst_go ? S_SETUP : S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (accept) begin
      tx_d  = bus.word_to_send;
      rx_d  = '0;
      bit_d = '0;
    end else if (state_q == S_SHIFT_HI && div_last) begin
      // Zeros fill TX so out_bit rests low once the word is out.
      tx_d  = {tx_q[WORD_BITS-2:0], 1'b0};
      rx_d  = {rx_q[WORD_BITS-2:0], bus.in_bit};
      bit_d = bit_q + BIT_W'(1);
    end
  end

  // Outputs decode the next state so every pin comes straight from a flop.
  always_comb begin
    sck_d           = (state_d == S_SHIFT_HI);
    neg_enable_d    = (state_d == S_IDLE);
    busy_d          = (state_d != S_IDLE);
    done_d          = (state_q == S_HOLD) && div_last;
    out_bit_d       = tx_d[WORD_BITS-1];
    word_received_d = done_d ? rx_q : word_received_q;
  end

  assign bus.sck           = sck_q;
  assign bus.neg_enable    = neg_enable_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.out_bit       = out_bit_q;
  assign bus.word_received = word_received_q;

endmodule

// File: tb/tb_spi_main.sv
// Self-checking bench for spi_main: vector table, randomized transfers, and
// hand sequences for start-while-busy, mid-transfer reset and a 16-bit instance.
module tb_spi_main;

  localparam int WB  = 8;
  localparam int CD  = 4;
  localparam int LAT = 1 + (2 * WB + 1) * CD;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  spi_main_if #(.WORD_BITS(WB)) bus8 ();
  spi_main_if #(.WORD_BITS(16)) bus16 ();

  logic loop_mode;
  logic miso_drv;
  assign bus8.in_bit  = loop_mode ? bus8.out_bit : miso_drv;
  assign bus16.in_bit = bus16.out_bit;

  spi_main #(.WORD_BITS(WB), .CLK_DIV(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  spi_main #(.WORD_BITS(16), .CLK_DIV(5)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] tx;
    logic       lp;
    logic [7:0] miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  int         res_lat, res_rises, res_first_rise, res_glitch, res_ncs_low;
  logic [7:0] res_rx, res_mosi;
  logic       res_busy_done, res_ncs_done, res_out_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: a transfer returns what appeared on MISO, MSB first.
  function automatic logic [7:0] model_rx(input logic [7:0] tx, input logic lp,
                                          input logic [7:0] miso);
    return lp ? tx : miso;
  endfunction

  task automatic run_xfer(input logic [7:0] tx, input logic lp, input logic [7:0] miso);
    int   n;
    int   falls;
    logic sck_p;
    logic out_p;
    loop_mode = lp;
    miso_drv  = miso[7];
    @(negedge clk);
    bus8.word_to_send = tx;
    bus8.start        = 1'b1;
    @(posedge clk);
    #1;
    bus8.start     = 1'b0;
    res_lat        = -1;
    res_rises      = 0;
    res_first_rise = -1;
    res_glitch     = 0;
    res_ncs_low    = 0;
    res_mosi       = '0;
    res_rx         = '0;
    sck_p          = 1'b0;
    out_p          = bus8.out_bit;
    n              = 1;
    falls          = 0;
    while (n <= 200 && res_lat < 0) begin
      if (bus8.sck && !sck_p) begin
        res_rises++;
        res_mosi = {res_mosi[6:0], bus8.out_bit};
        if (res_first_rise < 0) res_first_rise = n;
      end
      if (!bus8.sck && sck_p) begin
        falls++;
        if (falls < 8) miso_drv = miso[7-falls];
      end
      if (bus8.sck && (bus8.out_bit != out_p)) res_glitch++;
      if (!bus8.neg_enable) res_ncs_low++;
      sck_p = bus8.sck;
      out_p = bus8.out_bit;
      if (bus8.done) begin
        res_lat       = n;
        res_rx        = bus8.word_received;
        res_busy_done = bus8.busy;
        res_ncs_done  = bus8.neg_enable;
        res_out_done  = bus8.out_bit;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
  endtask

  task automatic busy_sequence();
    int         n;
    int         ndone;
    int         ncs_hi;
    int         done_at[2];
    logic [7:0] done_val[2];
    logic       ncs69, busy70;
    int         exp_done2, exp_ncs_hi;
    logic       exp_ncs69;
`ifdef SPI_MAIN_BURST_EN
    exp_done2  = LAT + 1 + (2 * WB + 1) * CD - 1;
    exp_ncs_hi = 0;
    exp_ncs69  = 1'b0;
`else
    exp_done2  = 2 * LAT;
    exp_ncs_hi = 1;
    exp_ncs69  = 1'b1;
`endif
    loop_mode   = 1'b1;
    ndone       = 0;
    ncs_hi      = 0;
    done_at[0]  = -1;
    done_at[1]  = -1;
    done_val[0] = '0;
    done_val[1] = '0;
    ncs69       = 1'b0;
    busy70      = 1'b0;
    @(negedge clk);
    bus8.word_to_send = 8'h3C;
    bus8.start        = 1'b1;
    @(posedge clk);
    #1;
    n = 1;
    while (n <= 200) begin
      if (n == 10) bus8.word_to_send = 8'h99;
      if (n == 100) bus8.start = 1'b0;
      if (bus8.done) begin
        if (ndone < 2) begin
          done_at[ndone]  = n;
          done_val[ndone] = bus8.word_received;
        end
        ndone++;
      end
      if (n == 69) ncs69 = bus8.neg_enable;
      if (n == 70) busy70 = bus8.busy;
      if (bus8.neg_enable && n < 137) ncs_hi++;
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_done1_time", done_at[0], LAT);
    check("busy_done1_word", done_val[0], 8'h3C);
    check("busy_done_count", ndone, 2);
    check("busy_done2_time", done_at[1], exp_done2);
    check("busy_done2_word", done_val[1], 8'h99);
    check("busy_ncs_at_69", ncs69, exp_ncs69);
    check("busy_ncs_high_cycles", ncs_hi, exp_ncs_hi);
    check("busy_at_70", busy70, 1'b1);
  endtask

  task automatic reset_sequence();
    run_xfer(8'hE7, 1'b1, 8'h00);
    check("pre_reset_rx", res_rx, 8'hE7);
    loop_mode = 1'b1;
    @(negedge clk);
    bus8.word_to_send = 8'hC3;
    bus8.start        = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("mid_xfer_busy", bus8.busy, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_ncs", bus8.neg_enable, 1'b1);
    check("rst_sck", bus8.sck, 1'b0);
    check("rst_out", bus8.out_bit, 1'b0);
    check("rst_busy", bus8.busy, 1'b0);
    check("rst_done", bus8.done, 1'b0);
    check("rst_word", bus8.word_received, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_word", bus8.word_received, 8'h00);
    check("post_rst_busy", bus8.busy, 1'b0);
    run_xfer(8'h5A, 1'b1, 8'h00);
    check("after_rst_rx", res_rx, 8'h5A);
    check("after_rst_lat", res_lat, LAT);
    check("after_rst_mosi", res_mosi, 8'h5A);
  endtask

  task automatic wide_sequence();
    int          n;
    int          lat16;
    int          rises16;
    logic        sp;
    logic [15:0] rx16;
    @(negedge clk);
    bus16.word_to_send = 16'hBEEF;
    bus16.start        = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    n       = 1;
    lat16   = -1;
    rises16 = 0;
    sp      = 1'b0;
    rx16    = '0;
    while (n <= 400 && lat16 < 0) begin
      if (bus16.sck && !sp) rises16++;
      sp = bus16.sck;
      if (bus16.done) begin
        lat16 = n;
        rx16  = bus16.word_received;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("w16_lat", lat16, 1 + 33 * 5);
    check("w16_rx", rx16, 16'hBEEF);
    check("w16_rises", rises16, 16);
  endtask

  initial begin
    logic [7:0] rtx, rmiso;
    logic       rlp;
    checks             = 0;
    failures           = 0;
    loop_mode          = 1'b1;
    miso_drv           = 1'b0;
    bus8.start         = 1'b0;
    bus8.word_to_send  = '0;
    bus16.start        = 1'b0;
    bus16.word_to_send = '0;
    rst                = 1'b1;
    #2;
    rst = 1'b0;

    vecs[0] = '{tx: 8'hA5, lp: 1'b1, miso: 8'h00, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'h00, lp: 1'b0, miso: 8'hFF, exp_rx: 8'hFF};
    vecs[2] = '{tx: 8'h3C, lp: 1'b1, miso: 8'h00, exp_rx: 8'h3C};
    vecs[3] = '{tx: 8'hFF, lp: 1'b0, miso: 8'h00, exp_rx: 8'h00};
    vecs[4] = '{tx: 8'h81, lp: 1'b0, miso: 8'h5A, exp_rx: 8'h5A};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ncs", bus8.neg_enable, 1'b1);
    check("reset_sck", bus8.sck, 1'b0);
    check("reset_busy", bus8.busy, 1'b0);
    check("reset_done", bus8.done, 1'b0);
    check("reset_out", bus8.out_bit, 1'b0);
    check("reset_word", bus8.word_received, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].tx, vecs[i].lp, vecs[i].miso);
      check($sformatf("vec%0d_rx", i), res_rx, vecs[i].exp_rx);
      check($sformatf("vec%0d_lat", i), res_lat, LAT);
      check($sformatf("vec%0d_rises", i), res_rises, WB);
      check($sformatf("vec%0d_mosi", i), res_mosi, vecs[i].tx);
      check($sformatf("vec%0d_first_rise", i), res_first_rise, 1 + CD);
      check($sformatf("vec%0d_out_glitch", i), res_glitch, 0);
      check($sformatf("vec%0d_ncs_low", i), res_ncs_low, LAT - 1);
      check($sformatf("vec%0d_busy_done", i), res_busy_done, 1'b0);
      check($sformatf("vec%0d_ncs_done", i), res_ncs_done, 1'b1);
      check($sformatf("vec%0d_out_done", i), res_out_done, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      rtx   = 8'($urandom);
      rmiso = 8'($urandom);
      rlp   = 1'($urandom_range(0, 1));
      run_xfer(rtx, rlp, rmiso);
      check($sformatf("rand%0d_rx", i), res_rx, model_rx(rtx, rlp, rmiso));
      check($sformatf("rand%0d_lat", i), res_lat, LAT);
      check($sformatf("rand%0d_mosi", i), res_mosi, rtx);
    end

    busy_sequence();
    reset_sequence();
    wide_sequence();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_main.md
# spi_main

- SPI controller (mode 0, MSB first) that drives the chip-select, clock and data lines consumed by our SPI secondary receiver.
- Exchanges one `WORD_BITS` word per `start` request: shifts `word_to_send` out on `out_bit` while sampling `in_bit`, then presents the received word with a one-cycle `done` pulse.
- Sits between the FPGA-side command logic and the external SPI pins.
- Also serves as the loopback stimulus source for secondary-side benches.

## Interface
Parameters:
- `WORD_BITS`, default 8: bits per transfer; must be ≥ 2.
- `CLK_DIV`, default 4: `clk` cycles per `sck` half-period. Must be ≥ 4 so the secondary's 3-stage `sck` edge detector sees every edge.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request a transfer; sampled only when `busy` = 0.
- `word_to_send` in `WORD_BITS`: data to send; latched on the accepting cycle.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle pulse when a transfer completes.
- `word_received` out `WORD_BITS`: last completed received word; held until the next `done`.
- `neg_enable` out 1: active-low chip select.
- `sck` out 1: SPI clock; idles low.
- `out_bit` out 1: MOSI.
- `in_bit` in 1: MISO. Synchronous to `sck`; no extra synchronizer inside.

## Operation
- FSM states: IDLE → SETUP → SHIFT_HI ↔ SHIFT_LO → HOLD → IDLE.
- A single divider counter runs 0..`CLK_DIV`-1. A bit counter of width `$clog2(WORD_BITS)+1` counts bits.
- **IDLE**
  - Outputs: `neg_enable`=1, `sck`=0, `busy`=0.
  - If `start`=1: latch `word_to_send` into the TX shift register and go to SETUP.
- **SETUP** (`CLK_DIV` cycles)
  - `neg_enable`=0, `out_bit`=TX MSB, `sck`=0.
  - Exits to SHIFT_HI.
- **SHIFT_HI** (`CLK_DIV` cycles)
  - `sck`=1.
  - On the last cycle:
    - Shift `in_bit` into the LSB of the RX shift register.
    - Shift TX left; `out_bit` takes the next bit.
    - Increment the bit counter.
  - If the bit counter reaches `WORD_BITS`, go to HOLD. Otherwise go to SHIFT_LO.
- **SHIFT_LO** (`CLK_DIV` cycles)
  - `sck`=0, `out_bit` stable.
  - Exits to SHIFT_HI.
- **HOLD** (`CLK_DIV` cycles)
  - `sck`=0, `neg_enable`=0.
  - On exit: `neg_enable`=1, `word_received` ← RX, `done`=1 for one cycle, `busy`=0, return to IDLE.
- `out_bit` after the last bit is 0 (TX shifts in zeros).
- `start` while `busy`=1 is ignored and not queued. `word_to_send` changes while busy have no effect.
- Reset, asynchronous, at any time including mid-transfer, forces:
  - `neg_enable`=1, `sck`=0, `out_bit`=0, `busy`=0, `done`=0, `word_received`=0.
  - FSM = IDLE; TX, RX and both counters cleared.
  - The aborted word is discarded.

## Timing
- `start` is sampled high at edge T. Then:
  - `busy`=1 and `neg_enable`=0 from T+1.
  - First `sck` rise at T+1+`CLK_DIV`.
  - Bit k (k=0 is the MSB) is sampled on the edge where `sck` falls: T+1+(2k+2)·`CLK_DIV`.
  - Last `sck` fall at T+1+2·`WORD_BITS`·`CLK_DIV`.
  - `done`=1, `neg_enable`=1, `busy`=0 and `word_received` valid at T+1+(2·`WORD_BITS`+1)·`CLK_DIV`.
- Defaults: `done` at T+69.
- `sck` period is 2·`CLK_DIV` `clk` cycles, 50% duty.
- `out_bit` changes only while `sck` is 0 or coincident with a falling `sck` edge. It is held ≥ `CLK_DIV` cycles before each rise.
- Minimum chip-select high time between transfers: 1 cycle, since `start` is accepted in the `done` cycle's following IDLE cycle.
- All outputs are registered.

## Configuration
- Macro: `SPI_MAIN_BURST_EN`.
- **Defined:**
  - If `start`=1 on the last HOLD cycle, the new `word_to_send` is latched there.
  - `neg_enable` stays 0, and `done` still pulses for the finished word.
  - The FSM goes directly to SETUP; the next word's first `sck` rise is `CLK_DIV`+1 cycles later.
  - `busy` stays 1.
- **Undefined:**
  - `start` during HOLD is ignored.
  - `neg_enable` always returns to 1 for at least one cycle between words.

## Test plan
- **Loopback** (`out_bit`→`in_bit`), defaults, `word_to_send`=0xA5 with `start` pulsed at T → `word_received`=0xA5, `done` at T+69, 8 `sck` rises, `neg_enable` low T+1..T+68.
- **MISO tied high**, `word_to_send`=0x00 → `word_received`=0xFF, `out_bit` 0 throughout.
- **Start while busy**: `start` held high from T for 100 cycles with 0x3C, loopback → first `done` T+69 with 0x3C.
  - Without the macro: `neg_enable` high at T+69, second transfer accepted at T+70.
  - With the macro: `neg_enable` never rises, second `done` at T+69+1+(2·8+1)·4 − 1.
- **Reset asserted** at T+30 mid-transfer → all outputs reset values in the same cycle. A fresh transfer of 0x5A after release yields 0x5A, with no residue from the aborted word.
- **`WORD_BITS`=16, `CLK_DIV`=5**, loopback 0xBEEF → 0xBEEF, `done` at T+1+33·5=T+166.
- **Connected to the SPI secondary**, `word_to_send`=0x81 → the secondary's received word = 0x81 with its ready flag asserted exactly once.
